// File: rtl/conv_engine_p.sv
// Sequential KxK 2-D convolution engine: reads one tap per cycle from an external image store,
// multiplies by a captured signed kernel and emits one result per output pixel in raster order.
module conv_engine_p #(
  parameter int IMG_ROWS = 10,
  parameter int IMG_COLS = 12,
  parameter int K        = 3,
  parameter int PIX_W    = 4,
  parameter int COEF_W   = 8,
  parameter int ACC_W    = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stride2,
  input  logic                          relu_en,
  input  logic [K*K*COEF_W-1:0]         kernel_flat,
  output logic                          img_rd_en,
  output logic [$clog2(IMG_ROWS)-1:0]   img_row,
  output logic [$clog2(IMG_COLS)-1:0]   img_col,
  input  logic [PIX_W-1:0]              img_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_data,
  output logic                          out_eol,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   cycle_cnt
);

  localparam int RW  = $clog2(IMG_ROWS);
  localparam int CW  = $clog2(IMG_COLS);
  localparam int NT  = K * K;
  localparam int TW  = $clog2(NT + 1);
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int OR1 = IMG_ROWS - K + 1;
  localparam int OC1 = IMG_COLS - K + 1;
  localparam int OR2 = (IMG_ROWS - K) / 2 + 1;
  localparam int OC2 = (IMG_COLS - K) / 2 + 1;

  if (K > IMG_ROWS || K > IMG_COLS) begin : g_bad_kernel
    $error("conv_engine_p: kernel larger than image");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StCalc, StEmit} state_e;

  state_e                   state_q, state_d;
  logic [K*K*COEF_W-1:0]    kernel_q, kernel_d;
  logic                     stride_q, stride_d;
  logic                     relu_q, relu_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [15:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic [TW-1:0]            tap_cnt_q, tap_cnt_d;
  logic [KW-1:0]            tap_r_q, tap_r_d;
  logic [KW-1:0]            tap_c_q, tap_c_d;

  logic                     rd_now;
  logic                     col_end, row_end;
  logic [RW-1:0]            base_row;
  logic [CW-1:0]            base_col;
  logic [TW-1:0]            coef_idx;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [ACC_W-1:0]  pix_ext, coef_ext, prod;

  assign rd_now   = (state_q == StCalc) && (tap_cnt_q < TW'(NT));
  assign col_end  = col_q == (stride_q ? CW'(OC2 - 1) : CW'(OC1 - 1));
  assign row_end  = row_q == (stride_q ? RW'(OR2 - 1) : RW'(OR1 - 1));
  assign base_row = stride_q ? (row_q << 1) : row_q;
  assign base_col = stride_q ? (col_q << 1) : col_q;

  // Pixel returned this cycle belongs to the tap issued one cycle earlier.
  assign coef_idx = (tap_cnt_q == '0) ? '0 : tap_cnt_q - 1'b1;
  assign coef_sel = kernel_q[coef_idx*COEF_W +: COEF_W];
  assign pix_ext  = ACC_W'(img_data);
  assign coef_ext = ACC_W'(coef_sel);
  assign prod     = pix_ext * coef_ext;

  always_comb begin
    state_d   = state_q;
    kernel_d  = kernel_q;
    stride_d  = stride_q;
    relu_d    = relu_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    row_d     = row_q;
    col_d     = col_q;
    tap_cnt_d = tap_cnt_q;
    tap_r_d   = tap_r_q;
    tap_c_d   = tap_c_q;

    if (busy_q && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          kernel_d = kernel_flat;
          stride_d = stride2;
          relu_d   = relu_en;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        row_d     = '0;
        col_d     = '0;
        acc_d     = '0;
        tap_cnt_d = '0;
        tap_r_d   = '0;
        tap_c_d   = '0;
        state_d   = StCalc;
      end
      StCalc: begin
        if (tap_cnt_q != '0) begin
          acc_d = acc_q + prod;
        end
        if (tap_cnt_q == TW'(NT)) begin
          tap_cnt_d = '0;
          tap_r_d   = '0;
          tap_c_d   = '0;
          state_d   = StEmit;
        end else begin
          tap_cnt_d = tap_cnt_q + 1'b1;
          if (tap_c_q == KW'(K - 1)) begin
            tap_c_d = '0;
            tap_r_d = tap_r_q + 1'b1;
          end else begin
            tap_c_d = tap_c_q + 1'b1;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          acc_d = '0;
          if (col_end && row_end) begin
            row_d   = '0;
            col_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StCalc;
            if (col_end) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      kernel_q  <= '0;
      stride_q  <= 1'b0;
      relu_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      tap_cnt_q <= '0;
      tap_r_q   <= '0;
      tap_c_q   <= '0;
    end else begin
      state_q   <= state_d;
      kernel_q  <= kernel_d;
      stride_q  <= stride_d;
      relu_q    <= relu_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      row_q     <= row_d;
      col_q     <= col_d;
      tap_cnt_q <= tap_cnt_d;
      tap_r_q   <= tap_r_d;
      tap_c_q   <= tap_c_d;
    end
  end

  assign img_rd_en = rd_now;
  assign img_row   = rd_now ? base_row + RW'(tap_r_q) : '0;
  assign img_col   = rd_now ? base_col + CW'(tap_c_q) : '0;

  assign out_valid = state_q == StEmit;
  assign out_data  = !out_valid ? '0 : (relu_q && acc_q[ACC_W-1]) ? '0 : acc_q;
  assign out_eol   = out_valid && col_end;
  assign out_last  = out_valid && col_end && row_end;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_conv_engine_p.sv
// Directed bench for conv_engine_p: an image-store model, a loop-based convolution scoreboard
// and literal expectations for the characteristic runs.
module tb_conv_engine_p;
  localparam int R   = 10;
  localparam int C   = 12;
  localparam int K   = 3;
  localparam int PW  = 4;
  localparam int CFW = 8;
  localparam int AW  = 20;

  logic               clk = 1'b0;
  logic               rst, start, stride2, relu_en, out_ready;
  logic [K*K*CFW-1:0] kernel_flat;
  logic               img_rd_en;
  logic [3:0]         img_row, img_col;
  logic [PW-1:0]      img_data;
  logic               out_valid, out_eol, out_last, busy, done;
  logic [AW-1:0]      out_data;
  logic [15:0]        cycle_cnt;

  conv_engine_p dut (
    .clk(clk), .rst(rst), .start(start), .stride2(stride2), .relu_en(relu_en),
    .kernel_flat(kernel_flat), .img_rd_en(img_rd_en), .img_row(img_row),
    .img_col(img_col), .img_data(img_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_eol(out_eol), .out_last(out_last), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int data; bit eol; bit last;} res_t;

  int          img_mem [R][C];
  int          coef    [K][K];
  int          m_coef  [K][K];
  bit          m_s, m_relu;
  res_t        exp_q[$];
  int          got [100];
  int          n_got;
  int          checks, errors;
  int          cyc = 0;
  bit          hold_prev;
  logic [AW-1:0] prev_data;
  logic        prev_eol, prev_last;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Image store: data appears one cycle after the read strobe; junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (img_rd_en && int'(img_row) < R && int'(img_col) < C)
      img_data <= PW'(img_mem[int'(img_row)][int'(img_col)]);
    else
      img_data <= PW'(cyc * 7 + 3);
  end

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (img_rd_en) begin
        check("rd_addr_range", (int'(img_row) < R) && (int'(img_col) < C), 1);
        check("rd_while_busy", busy, 1);
      end
      if (out_valid) begin
        if (hold_prev) begin
          check("hold_data", out_data, prev_data);
          check("hold_eol", out_eol, prev_eol);
          check("hold_last", out_last, prev_last);
        end
        check("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("out_data", int'($signed(out_data)), exp_q[0].data);
          check("out_eol", out_eol, exp_q[0].eol);
          check("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            if (n_got < 100) got[n_got] = int'($signed(out_data));
            n_got++;
            void'(exp_q.pop_front());
          end
        end
        hold_prev = !out_ready;
        prev_data = out_data;
        prev_eol  = out_eol;
        prev_last = out_last;
      end else begin
        check("valid_held_while_stalled", hold_prev, 0);
        hold_prev = 1'b0;
      end
    end
  end

  task automatic fill_img(input int mode);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        case (mode)
          0:       img_mem[r][c] = 15;
          1:       img_mem[r][c] = (r + c) % 16;
          default: img_mem[r][c] = (r * 5 + c * 3 + 1) % 16;
        endcase
  endtask

  task automatic fill_coef(input int mode);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        case (mode)
          0:       coef[r][c] = 1;
          1:       coef[r][c] = (r == 1 && c == 1) ? 1 : 0;
          2:       coef[r][c] = -1;
          3:       coef[r][c] = 0;
          default: coef[r][c] = r * 3 + c - 4;
        endcase
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        kernel_flat[(r*K+c)*CFW +: CFW] = CFW'(coef[r][c]);
  endtask

  task automatic build_expected();
    int s, nr, nc, sum;
    s  = m_s ? 2 : 1;
    nr = (R - K) / s + 1;
    nc = (C - K) / s + 1;
    exp_q.delete();
    for (int i = 0; i < nr; i++)
      for (int j = 0; j < nc; j++) begin
        sum = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            sum += img_mem[i*s+r][j*s+c] * m_coef[r][c];
        if (m_relu && sum < 0) sum = 0;
        exp_q.push_back('{sum, j == nc - 1, (i == nr - 1) && (j == nc - 1)});
      end
  endtask

  task automatic begin_run(input bit s, input bit relu);
    m_coef = coef;
    m_s    = s;
    m_relu = relu;
    build_expected();
    n_got = 0;
    @(posedge clk); #1;
    stride2 = s;
    relu_en = relu;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int n_exp);
    bit seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_count"}, n_got, n_exp);
    check({tag, "_leftover"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_eol"}, out_eol, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_rd_en"}, img_rd_en, 0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
  endtask

  initial begin
    bit hit;
    checks = 0; errors = 0; n_got = 0;
    rst = 1'b1; start = 1'b0; stride2 = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
    kernel_flat = '0;
    #12;
    check_reset("reset_init");
    @(posedge clk); #3 rst = 1'b0;

    // Flat image, unit kernel: every window sums to 9*15.
    fill_img(0); fill_coef(0);
    begin_run(1'b0, 1'b0);
    finish_run("run_flat", 80);
    check("flat_cycle_cnt", cycle_cnt, 881);
    check("flat_first", got[0], 135);
    check("flat_last", got[79], 135);
    repeat (3) @(negedge clk);
    check("flat_cycle_cnt_hold", cycle_cnt, 881);

    // Diagonal ramp with centre-only kernel: out(i,j) = (i+1+j+1) % 16.
    fill_img(1); fill_coef(1);
    begin_run(1'b0, 1'b0);
    finish_run("run_centre", 80);
    check("centre_0_0", got[0], 2);
    check("centre_7_9", got[7*10+9], 2);
    check("centre_3_4", got[3*10+4], 9);

    fill_img(0); fill_coef(0);
    begin_run(1'b1, 1'b0);
    finish_run("run_stride2", 20);
    check("stride2_first", got[0], 135);
    check("stride2_last", got[19], 135);

    fill_coef(2);
    begin_run(1'b1, 1'b0);
    finish_run("run_neg", 20);
    check("neg_first", got[0], -135);
    check("neg_mid", got[7], -135);
    begin_run(1'b1, 1'b1);
    finish_run("run_relu", 20);
    check("relu_first", got[0], 0);

    // Backpressure, mid-run start and mid-run kernel/mode changes.
    fill_img(2); fill_coef(4);
    begin_run(1'b0, 1'b0);
    out_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (out_valid) hit = 1'b1;
    end
    check("bp_first_valid", hit, 1);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid_stalled", out_valid, 1);
    end
    out_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    fill_coef(3);
    stride2 = 1'b1; relu_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      out_ready = i[0];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    finish_run("run_bp", 80);

    // Reset in the middle of a run, then a clean full run.
    fill_img(0); fill_coef(0);
    begin_run(1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (n_got >= 37) hit = 1'b1;
    end
    check("abort_reached_37", hit, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1 check_reset("reset_mid");
    exp_q.delete();
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    check_reset("reset_after");
    begin_run(1'b0, 1'b0);
    finish_run("run_after_abort", 80);
    check("after_abort_cycle_cnt", cycle_cnt, 881);
    check("after_abort_last", got[79], 135);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
